fetch_prefetch: RTL and testbench

FETCH_PREFETCH -- requirements
Module: fetch_prefetch

---
 rtl/fetch_pkg.sv | 16 +
 rtl/fetch_fifo.sv | 54 +++++
 rtl/fetch_prefetch.sv | 142 ++++++++++++++
 tb/tb_fetch_prefetch.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// fetch_pkg: shared defaults and the prefetch queue entry type for the
// fetch_prefetch slice.
//   FETCH_BASEADDR_DEFAULT : PC loaded at reset
//   FETCH_DEPTH_DEFAULT    : prefetch queue entries
//   fetch_entry_t          : {pc, insn} record stored per queue slot
package fetch_pkg;

  localparam logic [31:0]  FETCH_BASEADDR_DEFAULT = 32'h0100_0000;
  localparam int unsigned  FETCH_DEPTH_DEFAULT    = 4;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] insn;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: DEPTH-entry circular buffer for prefetched instructions.
// Ports:
//   clk, reset      : clock, synchronous active-high reset
//   push_i/push_data_i : write one entry (ignored when full without a pop)
//   pop_i           : retire the head entry (ignored when empty)
//   flush_i         : empty the buffer; dominates push and pop
//   head_o          : oldest entry
//   count_o         : number of valid entries (0..DEPTH)
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int unsigned DEPTH = FETCH_DEPTH_DEFAULT,
  parameter type entry_t = fetch_entry_t
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 push_i,
  input  entry_t               push_data_i,
  input  logic                 pop_i,
  input  logic                 flush_i,
  output entry_t               head_o,
  output logic [$clog2(DEPTH):0] count_o
);

  localparam int unsigned PW = $clog2(DEPTH);

  entry_t         mem [DEPTH];
  logic [PW-1:0]  rd_ptr;
  logic [PW-1:0]  wr_ptr;
  logic           do_push;
  logic           do_pop;

  assign do_pop  = pop_i && (count_o != '0);
  assign do_push = push_i && ((count_o != (PW+1)'(DEPTH)) || do_pop);
  assign head_o  = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (reset || flush_i) begin
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      count_o <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count_o <= count_o + (PW+1)'(do_push) - (PW+1)'(do_pop);
    end
  end

  // Storage needs no reset; validity is tracked by the pointers.
  always_ff @(posedge clk) begin
    if (do_push && !reset && !flush_i) mem[wr_ptr] <= push_data_i;
  end

endmodule

// File: rtl/fetch_prefetch.sv
// fetch_prefetch: instruction prefetcher with an in-order memory interface,
// credit-based request throttling and redirect handling with stale-response
// dropping.
// Ports:
//   clk, reset                 : clock, synchronous active-high reset
//   redirect_i, redirect_pc_i  : execute-stage PC redirect and target
//   imem_req_o, imem_addr_o    : instruction-memory read request/address
//   imem_gnt_i                 : request accepted this cycle
//   imem_rvalid_i, imem_rdata_i: in-order read response
//   dec_valid_o/dec_ready_i    : queue head handshake toward decode
//   dec_pc_o, dec_insn_o       : head PC and instruction
// Optional (macro FETCH_PERF_CNT_EN):
//   perf_fetched_o             : saturating count of pops to decode
//   perf_flushed_o             : saturating count of flushed entries + drops
module fetch_prefetch
  import fetch_pkg::*;
#(
  parameter int unsigned       AWIDTH   = 32,
  parameter int unsigned       DWIDTH   = 32,
  parameter logic [AWIDTH-1:0] BASEADDR = AWIDTH'(FETCH_BASEADDR_DEFAULT),
  parameter int unsigned       DEPTH    = FETCH_DEPTH_DEFAULT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              redirect_i,
  input  logic [AWIDTH-1:0] redirect_pc_i,
  output logic              imem_req_o,
  output logic [AWIDTH-1:0] imem_addr_o,
  input  logic              imem_gnt_i,
  input  logic              imem_rvalid_i,
  input  logic [DWIDTH-1:0] imem_rdata_i,
  output logic              dec_valid_o,
  input  logic              dec_ready_i,
  output logic [AWIDTH-1:0] dec_pc_o,
  output logic [DWIDTH-1:0] dec_insn_o
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]       perf_fetched_o,
  output logic [31:0]       perf_flushed_o
`endif
);

  typedef struct packed {
    logic [AWIDTH-1:0] pc;
    logic [DWIDTH-1:0] insn;
  } entry_t;

  localparam int unsigned CW = $clog2(DEPTH) + 2;
  localparam int unsigned QW = $clog2(DEPTH) + 1;

  logic [AWIDTH-1:0] fetch_pc;
  logic [AWIDTH-1:0] resp_pc;
  logic [AWIDTH-1:0] redirect_target;
  logic [CW-1:0]     outstanding;
  logic [CW-1:0]     drop_count;
  logic [CW-1:0]     credit_used;
  logic [CW-1:0]     drop_pending;
  logic [QW-1:0]     q_count;
  logic              accept;
  logic              rv_drop;
  logic              rv_keep;
  logic              pop;
  entry_t            push_entry;
  entry_t            head;
  logic              unused_pc_bits;

  assign unused_pc_bits  = ^redirect_pc_i[1:0];
  assign redirect_target = {redirect_pc_i[AWIDTH-1:2], 2'b00};

  // Every issued request already owns a queue slot, so the queue cannot overflow.
  assign credit_used = CW'(q_count) + outstanding + drop_count;
  assign imem_req_o  = !reset && !redirect_i && (credit_used < CW'(DEPTH));
  assign imem_addr_o = fetch_pc;
  assign accept      = imem_req_o && imem_gnt_i;

  // Responses are in order, so the oldest drop_count responses are stale.
  assign rv_drop = imem_rvalid_i && !reset && (redirect_i || (drop_count != '0));
  assign rv_keep = imem_rvalid_i && !reset && !rv_drop;

  assign dec_valid_o = !reset && (q_count != '0);
  assign pop         = dec_valid_o && dec_ready_i && !redirect_i;
  assign dec_pc_o    = head.pc;
  assign dec_insn_o  = head.insn;
  assign push_entry  = '{pc: resp_pc, insn: imem_rdata_i};

  // A response arriving in the redirect cycle retires one of the requests
  // that becomes a drop, so it is removed from the new drop total.
  assign drop_pending = drop_count + outstanding + CW'(accept);

  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_pc    <= BASEADDR;
      resp_pc     <= BASEADDR;
      outstanding <= '0;
      drop_count  <= '0;
    end else if (redirect_i) begin
      fetch_pc    <= redirect_target;
      resp_pc     <= redirect_target;
      outstanding <= '0;
      drop_count  <= (imem_rvalid_i && (drop_pending != '0)) ? drop_pending - CW'(1)
                                                             : drop_pending;
    end else begin
      if (accept)  fetch_pc <= fetch_pc + AWIDTH'(4);
      if (rv_keep) resp_pc  <= resp_pc + AWIDTH'(4);
      outstanding <= outstanding + CW'(accept) - CW'(rv_keep);
      if (rv_drop) drop_count <= drop_count - CW'(1);
    end
  end

  fetch_fifo #(
    .DEPTH   (DEPTH),
    .entry_t (entry_t)
  ) u_fifo (
    .clk         (clk),
    .reset       (reset),
    .push_i      (rv_keep),
    .push_data_i (push_entry),
    .pop_i       (pop),
    .flush_i     (redirect_i),
    .head_o      (head),
    .count_o     (q_count)
  );

`ifdef FETCH_PERF_CNT_EN
  logic [32:0] flushed_sum;

  assign flushed_sum = {1'b0, perf_flushed_o}
                     + 33'(redirect_i ? q_count : QW'(0))
                     + 33'(rv_drop);

  always_ff @(posedge clk) begin
    if (reset) begin
      perf_fetched_o <= '0;
      perf_flushed_o <= '0;
    end else begin
      if (pop && (perf_fetched_o != '1)) perf_fetched_o <= perf_fetched_o + 32'd1;
      perf_flushed_o <= flushed_sum[32] ? '1 : flushed_sum[31:0];
    end
  end
`endif

endmodule

// File: tb/tb_fetch_prefetch.sv
// tb_fetch_prefetch: self-checking bench for fetch_prefetch.
// A scripted vector table covers reset and the steady-state pipeline; hand
// sequences cover stall, redirect and grant-withheld corner cases; a random
// phase runs against an in-order memory model and a PC-stream reference.
// Perf counter ports are connected and checked when FETCH_PERF_CNT_EN is set.
module tb_fetch_prefetch;

  localparam logic [31:0] BASE  = 32'h0100_0000;
  localparam int unsigned DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        redirect_i = 1'b0;
  logic [31:0] redirect_pc_i = '0;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_gnt_i = 1'b0;
  logic        imem_rvalid_i = 1'b0;
  logic [31:0] imem_rdata_i = '0;
  logic        dec_valid_o;
  logic        dec_ready_i = 1'b0;
  logic [31:0] dec_pc_o;
  logic [31:0] dec_insn_o;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_fetched_o;
  logic [31:0] perf_flushed_o;
`endif

  fetch_prefetch #(
    .AWIDTH   (32),
    .DWIDTH   (32),
    .BASEADDR (BASE),
    .DEPTH    (DEPTH)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .redirect_i    (redirect_i),
    .redirect_pc_i (redirect_pc_i),
    .imem_req_o    (imem_req_o),
    .imem_addr_o   (imem_addr_o),
    .imem_gnt_i    (imem_gnt_i),
    .imem_rvalid_i (imem_rvalid_i),
    .imem_rdata_i  (imem_rdata_i),
    .dec_valid_o   (dec_valid_o),
    .dec_ready_i   (dec_ready_i),
    .dec_pc_o      (dec_pc_o),
    .dec_insn_o    (dec_insn_o)
`ifdef FETCH_PERF_CNT_EN
    ,
    .perf_fetched_o (perf_fetched_o),
    .perf_flushed_o (perf_flushed_o)
`endif
  );

  always #5 clk = ~clk;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  typedef struct {
    logic [31:0] addr;
    bit          stale;
  } pend_t;

  // Reference state: requests in flight at the memory (oldest first), number
  // of current-path instructions buffered, and the expected PC streams.
  pend_t       pending[$];
  int unsigned occ;
  logic [31:0] exp_req_addr;
  logic [31:0] exp_dec_pc;
  int unsigned accepts;
  int unsigned m_fetched;
  int unsigned m_flushed;

  logic        s_req, s_dv;
  logic [31:0] s_addr, s_pc, s_insn;

  function automatic logic [31:0] insn_of(input logic [31:0] pc);
    return {pc[15:0], ~pc[15:0]} ^ 32'h1357_9BDF;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: actual %0h required %0h at %0t", name, act, exp, $time);
  endtask

  task automatic model_clear();
    pending.delete();
    occ          = 0;
    exp_req_addr = BASE;
    exp_dec_pc   = BASE;
    accepts      = 0;
    m_fetched    = 0;
    m_flushed    = 0;
  endtask

  task automatic do_reset(input int unsigned cycles);
    @(negedge clk);
    reset         = 1'b1;
    imem_gnt_i    = 1'b1;
    imem_rvalid_i = 1'b1;
    imem_rdata_i  = '1;
    dec_ready_i   = 1'b1;
    redirect_i    = 1'b0;
    repeat (cycles) begin
      #1;
      chk("reset_req", 64'(imem_req_o), 64'(0));
      chk("reset_dec_valid", 64'(dec_valid_o), 64'(0));
      @(posedge clk);
    end
    #1;
    reset         = 1'b0;
    imem_gnt_i    = 1'b0;
    imem_rvalid_i = 1'b0;
    model_clear();
  endtask

  // One clock cycle: drive inputs, check outputs against the reference, then
  // advance the reference as the rising edge will advance the design.
  task automatic step(input bit gnt, input bit rv_want, input bit rdy,
                      input bit redir, input logic [31:0] tgt);
    pend_t       item;
    bit          take_rv, exp_req, acc, popped;
    int unsigned occ0;
    @(negedge clk);
    take_rv       = rv_want && (pending.size() != 0);
    imem_gnt_i    = gnt;
    imem_rvalid_i = take_rv;
    imem_rdata_i  = take_rv ? insn_of(pending[0].addr) : 32'h0;
    dec_ready_i   = rdy;
    redirect_i    = redir;
    redirect_pc_i = tgt;
    #1;
    s_req  = imem_req_o;
    s_addr = imem_addr_o;
    s_dv   = dec_valid_o;
    s_pc   = dec_pc_o;
    s_insn = dec_insn_o;
    exp_req = !redir && ((pending.size() + occ) < DEPTH);
    chk("req", 64'(s_req), 64'(exp_req));
    chk("dec_valid", 64'(s_dv), 64'(occ != 0));
    if (exp_req) chk("req_addr", 64'(s_addr), 64'(exp_req_addr));
    if (occ != 0) begin
      chk("dec_pc", 64'(s_pc), 64'(exp_dec_pc));
      chk("dec_insn", 64'(s_insn), 64'(insn_of(exp_dec_pc)));
    end
`ifdef FETCH_PERF_CNT_EN
    chk("perf_fetched", 64'(perf_fetched_o), 64'(m_fetched));
    chk("perf_flushed", 64'(perf_flushed_o), 64'(m_flushed));
`endif
    occ0   = occ;
    popped = (occ != 0) && rdy && !redir;
    if (popped) begin
      occ--;
      exp_dec_pc += 32'd4;
      m_fetched++;
    end
    if (take_rv) begin
      item = pending.pop_front();
      if (item.stale || redir) m_flushed++;
      else occ++;
    end
    acc = exp_req && gnt;
    if (acc) begin
      pending.push_back('{exp_req_addr, 1'b0});
      exp_req_addr += 32'd4;
      accepts++;
    end
    if (redir) begin
      m_flushed += occ0;
      occ = 0;
      foreach (pending[i]) pending[i].stale = 1'b1;
      exp_req_addr = {tgt[31:2], 2'b00};
      exp_dec_pc   = {tgt[31:2], 2'b00};
    end
  endtask

  typedef struct {
    bit          rst;
    bit          gnt;
    bit          rv;
    logic [31:0] rdata;
    bit          rdy;
    bit          exp_req;
    logic [31:0] exp_addr;
    bit          exp_dv;
    logic [31:0] exp_pc;
  } vec_t;

  vec_t vt[8];

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin : main
    bit seen;

    // Reset state, then the one-instruction-per-cycle pipeline from BASE.
    vt[0] = '{1'b1, 1'b1, 1'b1, 32'hFFFF_FFFF,        1'b1, 1'b0, 32'h0,        1'b0, 32'h0};
    vt[1] = '{1'b1, 1'b1, 1'b1, 32'hFFFF_FFFF,        1'b1, 1'b0, 32'h0,        1'b0, 32'h0};
    vt[2] = '{1'b0, 1'b1, 1'b0, 32'h0,                1'b1, 1'b1, BASE,         1'b0, 32'h0};
    vt[3] = '{1'b0, 1'b1, 1'b1, insn_of(BASE),        1'b1, 1'b1, BASE + 32'h4, 1'b0, 32'h0};
    vt[4] = '{1'b0, 1'b1, 1'b1, insn_of(BASE + 32'h4), 1'b1, 1'b1, BASE + 32'h8, 1'b1, BASE};
    vt[5] = '{1'b0, 1'b1, 1'b1, insn_of(BASE + 32'h8), 1'b1, 1'b1, BASE + 32'hC, 1'b1, BASE + 32'h4};
    vt[6] = '{1'b0, 1'b1, 1'b1, insn_of(BASE + 32'hC), 1'b1, 1'b1, BASE + 32'h10, 1'b1, BASE + 32'h8};
    vt[7] = '{1'b0, 1'b1, 1'b1, insn_of(BASE + 32'h10), 1'b1, 1'b1, BASE + 32'h14, 1'b1, BASE + 32'hC};

    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      reset         = vt[i].rst;
      imem_gnt_i    = vt[i].gnt;
      imem_rvalid_i = vt[i].rv;
      imem_rdata_i  = vt[i].rdata;
      dec_ready_i   = vt[i].rdy;
      redirect_i    = 1'b0;
      #1;
      chk("vec_req", 64'(imem_req_o), 64'(vt[i].exp_req));
      chk("vec_dec_valid", 64'(dec_valid_o), 64'(vt[i].exp_dv));
      if (vt[i].exp_req) chk("vec_addr", 64'(imem_addr_o), 64'(vt[i].exp_addr));
      if (vt[i].exp_dv) begin
        chk("vec_dec_pc", 64'(dec_pc_o), 64'(vt[i].exp_pc));
        chk("vec_dec_insn", 64'(dec_insn_o), 64'(insn_of(vt[i].exp_pc)));
      end
    end

    // Decode stalled: exactly DEPTH requests, head held, then drain in order.
    do_reset(2);
    repeat (10) begin
      step(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
      if (s_dv) chk("stall_head_pc", 64'(s_pc), 64'(BASE));
    end
    chk("stall_accepts", 64'(accepts), 64'(DEPTH));
    chk("stall_req_low", 64'(s_req), 64'(0));
    repeat (5) step(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);

    // Redirect with two requests outstanding; target is misaligned.
    do_reset(1);
    repeat (2) step(1'b1, 1'b0, 1'b1, 1'b0, 32'h0);
    step(1'b1, 1'b0, 1'b1, 1'b1, 32'h0100_0041);
    step(1'b1, 1'b0, 1'b1, 1'b0, 32'h0);
    chk("redir_first_req", 64'(s_req), 64'(1));
    chk("redir_first_addr", 64'(s_addr), 64'(32'h0100_0040));
    seen = 1'b0;
    for (int c = 0; c < 12; c++) begin
      step(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
      if (s_dv && !seen) begin
        seen = 1'b1;
        chk("redir_first_dec_pc", 64'(s_pc), 64'(32'h0100_0040));
      end
    end
    chk("redir_dec_seen", 64'(seen), 64'(1));

    // Redirect coinciding with a response and a pop.
    do_reset(1);
    repeat (3) step(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
    step(1'b1, 1'b1, 1'b1, 1'b1, 32'h0100_0100);
    step(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
    chk("flush_dec_valid", 64'(s_dv), 64'(0));
    seen = 1'b0;
    for (int c = 0; c < 12; c++) begin
      step(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
      if (s_dv && !seen) begin
        seen = 1'b1;
        chk("flush_first_dec_pc", 64'(s_pc), 64'(32'h0100_0100));
      end
    end
    chk("flush_dec_seen", 64'(seen), 64'(1));

    // Grant withheld: address held, nothing becomes outstanding.
    do_reset(1);
    repeat (5) begin
      step(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
      chk("nogrant_req", 64'(s_req), 64'(1));
      chk("nogrant_addr", 64'(s_addr), 64'(BASE));
    end
    repeat (6) step(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);

    // Random traffic against the reference, with occasional mid-run resets.
    do_reset(1);
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 599) == 0) do_reset(1);
      step($urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0,
           $urandom_range(0, 3) != 0, $urandom_range(0, 24) == 0,
           BASE + 32'($urandom_range(0, 255)));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
